fetch_pc_select: RTL and testbench
==================================

Name: fetch_pc_select

Overview:
Front end of the fetch stage. It holds the F-stage predicted-PC register and selects the fetch address for each cycle: the predicted PC, the fall-through of a mispredicted jump, or a return address. It also computes valP and the next prediction from the fetched icode, producing the PC that the PC-update logic consumes. It stops advancing once a halt or invalid instruction has been fetched.

Parameters:
RESET_PC, 64'd0, value loaded into F_predPC on reset
ICODE_W, 4, icode field width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
F_stall  input  1  hold F_predPC this cycle (from the hazard unit)
f_icode  input  4  icode of the instruction fetched at f_pc
f_valC  input  64  constant word of the instruction fetched at f_pc
f_imem_error  input  1  instruction memory error at f_pc
M_icode  input  4  icode in the M stage
M_Cnd  input  1  branch condition in the M stage
M_valA  input  64  fall-through PC carried by a jump in M
W_icode  input  4  icode in the W stage
W_valM  input  64  return address read by a ret in W
f_pc  output  64  fetch address for this cycle
f_valP  output  64  f_pc plus instruction length
F_predPC  output  64  registered predicted PC
f_halted  output  1  sticky: fetch has stopped

Behaviour:
- Reset, asynchronous on negedge rst_n:
  - F_predPC = RESET_PC.
  - FSM = RUN.
  - f_halted = 0.
  - Every combinational output follows from these values.
- f_pc selection, combinational, priority order:
  - (1) M_icode==JXX(7) && !M_Cnd -> f_pc = M_valA.
  - (2) else W_icode==RET(9) -> f_pc = W_valM.
  - (3) else f_pc = F_predPC.
- Instruction length from f_icode:
  - 1 for HALT(0), NOP(1), RET(9).
  - 2 for RRMOVQ/CMOV(2), OPQ(6), PUSHQ(A), POPQ(B).
  - 10 for IRMOVQ(3), RMMOVQ(4), MRMOVQ(5).
  - 9 for JXX(7), CALL(8).
  - Any other icode is invalid; length is 1.
- f_valP = f_pc + length, modulo 2^64. It wraps silently with no flag.
- Next prediction:
  - pred = f_valC when f_icode is JXX or CALL.
  - pred = f_valP otherwise.
- FSM states:
  - RUN:
    - If F_stall == 1, F_predPC holds.
    - Else if f_icode==HALT, or f_icode is invalid, or f_imem_error == 1: F_predPC = f_valP and go to HALTED.
    - Else F_predPC = pred.
  - HALTED:
    - F_predPC holds and f_halted = 1.
    - Only reset leaves this state.
    - Selection rules (1) and (2) still drive f_pc combinationally, but nothing is latched.
- F_stall and halt detection in the same cycle: the stall wins. F_predPC holds, the state stays RUN, and the halt is re-evaluated next cycle.
- A misprediction in M and a ret in W in the same cycle: M wins (priority 1).
- Latency:
  - f_pc and f_valP are same-cycle combinational.
  - F_predPC updates one cycle after selection.
- Reset mid-operation: immediate return to the reset values, with no dependence on the clock.

Decomposition:
- Shared package y86_pkg:
  - icode constants IHALT..IPOPQ.
  - WORD_W = 64.
  - FSM state enum {RUN, HALTED}.
  - function instr_len(icode).
- One natural sub-module, pc_select: purely combinational, implementing priority rules (1) to (3).
- The register, length, prediction and FSM logic stay in the top module.

Test Plan:
- Reset with RESET_PC=0x100, f_icode=NOP, no stall, 1 clk -> F_predPC=0x101, f_valP=0x101.
- f_icode=IRMOVQ at f_pc=0x0 -> f_valP=0xA, next F_predPC=0xA. Then f_icode=JXX, f_valC=0x40 -> next F_predPC=0x40.
- M_icode=7, M_Cnd=0, M_valA=0x13, W_icode=9, W_valM=0x80 in the same cycle -> f_pc=0x13. Drop the M condition -> f_pc=0x80.
- F_stall=1 for 3 cycles with f_icode=CALL, f_valC=0x200 -> F_predPC unchanged. Release the stall -> F_predPC=0x200.
- f_icode=HALT at f_pc=0x20 -> F_predPC=0x21 and f_halted=1. Later non-halt icodes -> F_predPC stays 0x21. Pulse rst_n low mid-cycle -> F_predPC=RESET_PC and f_halted=0 with no clock edge.
- f_pc=0xFFFF_FFFF_FFFF_FFFF with NOP -> f_valP=0x0 (wrap). Invalid icode 0xF -> length 1 and f_halted=1.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the fetch front end: icode values, word width,
// fetch FSM states and the instruction-length decode.
package y86_pkg;

  localparam int unsigned WORD_W = 64;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic {StRun, StHalted} fetch_state_e;

  function automatic logic icode_valid(input logic [3:0] icode);
    return icode <= IPOPQ;
  endfunction

  // Invalid icodes report length 1 so valP still points past the bad byte.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    logic [3:0] len;
    case (icode)
      IHALT, INOP, IRET:               len = 4'd1;
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:    len = 4'd2;
      IIRMOVQ, IRMMOVQ, IMRMOVQ:       len = 4'd10;
      IJXX, ICALL:                     len = 4'd9;
      default:                         len = 4'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/pc_select.sv
// Fetch-address mux: mispredicted jump in M beats ret in W beats the prediction.
module pc_select
  import y86_pkg::*;
(
  input  logic [3:0]        m_icode,
  input  logic              m_cnd,
  input  logic [WORD_W-1:0] m_val_a,
  input  logic [3:0]        w_icode,
  input  logic [WORD_W-1:0] w_val_m,
  input  logic [WORD_W-1:0] pred_pc,
  output logic [WORD_W-1:0] pc
);

  always_comb begin
    pc = pred_pc;
    if (m_icode == IJXX && !m_cnd) begin
      pc = m_val_a;
    end else if (w_icode == IRET) begin
      pc = w_val_m;
    end
  end

endmodule

// File: rtl/fetch_pc_select.sv
// Fetch front end: predicted-PC register, fetch-address selection, valP and
// next-PC prediction, and the sticky halt once HALT/invalid/imem error is fetched.
module fetch_pc_select
  import y86_pkg::*;
#(
  parameter logic [63:0]  RESET_PC = 64'd0,
  parameter int unsigned  ICODE_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               F_stall,
  input  logic [ICODE_W-1:0] f_icode,
  input  logic [63:0]        f_valC,
  input  logic               f_imem_error,
  input  logic [ICODE_W-1:0] M_icode,
  input  logic               M_Cnd,
  input  logic [63:0]        M_valA,
  input  logic [ICODE_W-1:0] W_icode,
  input  logic [63:0]        W_valM,
  output logic [63:0]        f_pc,
  output logic [63:0]        f_valP,
  output logic [63:0]        F_predPC,
  output logic               f_halted
);

  fetch_state_e      state_q, state_d;
  logic [63:0]       pred_pc_q, pred_pc_d;
  logic [3:0]        icode;
  logic [3:0]        len;
  logic [63:0]       pred;
  logic              stop;

  assign icode = f_icode[3:0];

  pc_select u_pc_select (
    .m_icode (M_icode[3:0]),
    .m_cnd   (M_Cnd),
    .m_val_a (M_valA),
    .w_icode (W_icode[3:0]),
    .w_val_m (W_valM),
    .pred_pc (pred_pc_q),
    .pc      (f_pc)
  );

  assign len    = instr_len(icode);
  assign f_valP = f_pc + {60'd0, len};
  assign pred   = (icode == IJXX || icode == ICALL) ? f_valC : f_valP;
  assign stop   = (icode == IHALT) || !icode_valid(icode) || f_imem_error;

  always_comb begin
    state_d   = state_q;
    pred_pc_d = pred_pc_q;
    unique case (state_q)
      StRun: begin
        // A stall masks halt detection; it is re-evaluated next cycle.
        if (!F_stall) begin
          if (stop) begin
            pred_pc_d = f_valP;
            state_d   = StHalted;
          end else begin
            pred_pc_d = pred;
          end
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      pred_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pred_pc_q <= pred_pc_d;
    end
  end

  assign F_predPC = pred_pc_q;
  assign f_halted = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_pc_select.sv
// Self-checking bench for fetch_pc_select: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch front end.
module tb_fetch_pc_select;

  localparam logic [63:0] RstPc = 64'h100;
  // Instruction length by icode; 0 marks an invalid icode.
  localparam int LenTab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 0, 0, 0, 0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        F_stall = 1'b0;
  logic [3:0]  f_icode = 4'h1;
  logic [63:0] f_valC = '0;
  logic        f_imem_error = 1'b0;
  logic [3:0]  M_icode = 4'h1;
  logic        M_Cnd = 1'b0;
  logic [63:0] M_valA = '0;
  logic [3:0]  W_icode = 4'h1;
  logic [63:0] W_valM = '0;
  logic [63:0] f_pc, f_valP, F_predPC;
  logic        f_halted;

  fetch_pc_select #(
    .RESET_PC (RstPc),
    .ICODE_W  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .F_stall      (F_stall),
    .f_icode      (f_icode),
    .f_valC       (f_valC),
    .f_imem_error (f_imem_error),
    .M_icode      (M_icode),
    .M_Cnd        (M_Cnd),
    .M_valA       (M_valA),
    .W_icode      (W_icode),
    .W_valM       (W_valM),
    .f_pc         (f_pc),
    .f_valP       (f_valP),
    .F_predPC     (F_predPC),
    .f_halted     (f_halted)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] m_pred = RstPc;
  bit          m_halted = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [63:0] valc, input bit err,
                       input bit stall, input logic [3:0] mi, input bit mc,
                       input logic [63:0] mva, input logic [3:0] wi, input logic [63:0] wvm);
    f_icode = ic; f_valC = valc; f_imem_error = err; F_stall = stall;
    M_icode = mi; M_Cnd = mc; M_valA = mva; W_icode = wi; W_valM = wvm;
  endtask

  // Check combinational outputs against the model, clock once, advance the model.
  task automatic step(input string tag);
    logic [63:0] epc, evp, npred;
    bit          nhalt, bad;
    int          len;
    #1;
    if (M_icode == 4'h7 && !M_Cnd) epc = M_valA;
    else if (W_icode == 4'h9)      epc = W_valM;
    else                           epc = m_pred;
    bad = (LenTab[f_icode] == 0);
    len = bad ? 1 : LenTab[f_icode];
    evp = epc + 64'(len);
    check_eq({tag, ".f_pc"}, f_pc, epc);
    check_eq({tag, ".f_valP"}, f_valP, evp);
    check_eq({tag, ".F_predPC"}, F_predPC, m_pred);
    check_eq({tag, ".f_halted"}, {63'd0, f_halted}, {63'd0, m_halted});
    npred = m_pred;
    nhalt = m_halted;
    if (!m_halted && !F_stall) begin
      if (f_icode == 4'h0 || bad || f_imem_error) begin
        npred = evp;
        nhalt = 1'b1;
      end else if (f_icode == 4'h7 || f_icode == 4'h8) begin
        npred = f_valC;
      end else begin
        npred = evp;
      end
    end
    @(posedge clk);
    m_pred   = npred;
    m_halted = nhalt;
    @(negedge clk);
  endtask

  // Asynchronous reset pulse well away from any clock edge.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    m_pred   = RstPc;
    m_halted = 1'b0;
    check_eq("reset.F_predPC", F_predPC, RstPc);
    check_eq("reset.f_halted", {63'd0, f_halted}, 64'd0);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [3:0] ic, mi, wi;
    @(negedge clk);
    pulse_reset();

    // NOP from reset PC
    drive(4'h1, '0, 0, 0, 4'h1, 0, '0, 4'h1, '0);
    #1 check_eq("nop.f_valP", f_valP, 64'h101);
    step("nop");
    check_eq("nop.next", F_predPC, 64'h101);

    // IRMOVQ at 0 via redirect, then JXX predicting valC
    drive(4'h3, '0, 0, 0, 4'h7, 0, 64'h0, 4'h1, '0);
    step("irmovq");
    check_eq("irmovq.next", F_predPC, 64'hA);
    drive(4'h7, 64'h40, 0, 0, 4'h1, 0, '0, 4'h1, '0);
    step("jxx");
    check_eq("jxx.next", F_predPC, 64'h40);

    // Redirect priority: M mispredict over W ret
    drive(4'h1, '0, 0, 1, 4'h7, 0, 64'h13, 4'h9, 64'h80);
    #1 check_eq("prio.m", f_pc, 64'h13);
    M_Cnd = 1'b1;
    #1 check_eq("prio.w", f_pc, 64'h80);
    step("prio");

    // Stall for three cycles on CALL, then release
    drive(4'h8, 64'h200, 0, 1, 4'h1, 0, '0, 4'h1, '0);
    for (int i = 0; i < 3; i++) step("stall");
    check_eq("stall.hold", F_predPC, 64'h40);
    F_stall = 1'b0;
    step("call");
    check_eq("call.next", F_predPC, 64'h200);

    // HALT at 0x20 is sticky until reset
    drive(4'h0, '0, 0, 0, 4'h7, 0, 64'h20, 4'h1, '0);
    step("halt");
    check_eq("halt.pc", F_predPC, 64'h21);
    check_eq("halt.flag", {63'd0, f_halted}, 64'd1);
    drive(4'h3, '0, 0, 0, 4'h1, 0, '0, 4'h1, '0);
    for (int i = 0; i < 3; i++) step("halted");
    check_eq("halted.hold", F_predPC, 64'h21);
    pulse_reset();

    // valP wraps at 2^64
    drive(4'h1, '0, 0, 1, 4'h7, 0, 64'hFFFF_FFFF_FFFF_FFFF, 4'h1, '0);
    #1 check_eq("wrap.f_valP", f_valP, 64'h0);
    step("wrap");

    // Stall beats halt detection in the same cycle
    drive(4'h0, '0, 0, 1, 4'h1, 0, '0, 4'h1, '0);
    step("stallhalt");
    check_eq("stallhalt.flag", {63'd0, f_halted}, 64'd0);

    // Invalid icode: length 1, halts
    drive(4'hF, '0, 0, 0, 4'h1, 0, '0, 4'h1, '0);
    step("invalid");
    check_eq("invalid.flag", {63'd0, f_halted}, 64'd1);
    check_eq("invalid.pc", F_predPC, 64'h101);
    pulse_reset();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 29) == 0) pulse_reset();
      if ($urandom_range(0, 3) != 0) ic = 4'($urandom_range(1, 11));
      else                           ic = 4'($urandom_range(0, 15));
      mi = ($urandom_range(0, 3) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
      wi = ($urandom_range(0, 4) == 0) ? 4'h9 : 4'($urandom_range(0, 15));
      drive(ic, {$urandom, $urandom}, ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 4) == 0), mi, 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, wi, {$urandom, $urandom});
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
